// File: rtl/run_detect_sched.sv
// Shared run-length detector: NCH serial channels, one detect datapath,
// round-robin grant per cycle, result tagged with channel and registered.
module run_detect_sched #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned THRESH = 4,
   parameter int unsigned CW     = 3,
   parameter int unsigned IW     = 2
) (
   input  logic            clk,
   input  logic            RESET,
   input  logic [NCH-1:0]  in_valid,
   input  logic [NCH-1:0]  in_bit,
   input  logic [NCH-1:0]  ch_clr,
   output logic [NCH-1:0]  in_ready,
   output logic            out_valid,
   output logic [IW-1:0]   out_ch,
   output logic            out,
   output logic            busy
);

   logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  cnt_q  [NCH];
   logic [CW-1:0]  cnt_d  [NCH];
   logic [NCH-1:0] last_q, last_d;
   logic [NCH-1:0] seen_q, seen_d;
   logic           out_valid_q, out_valid_d;
   logic [IW-1:0]  out_ch_q, out_ch_d;
   logic           out_q, out_d;

   logic [NCH-1:0] eligible;
   logic           grant_vld;
   logic [IW-1:0]  grant_idx;
   logic [IW-1:0]  scan_idx;
   logic           grant_bit;
   logic [CW-1:0]  new_cnt;

   assign eligible = in_valid & ~ch_clr;
   assign busy     = |in_valid;

   // Scan from rr_ptr upward; the IW-bit add wraps modulo NCH since NCH is 2^IW.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         scan_idx = rr_ptr_q + IW'(k);
         if (!grant_vld && eligible[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (RESET) begin
         grant_vld = 1'b0;
      end
   end

   assign in_ready  = grant_vld ? (NCH'(1) << grant_idx) : '0;
   assign grant_bit = in_bit[grant_idx];

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      seen_d      = seen_q;
      out_valid_d = 1'b0;
      out_ch_d    = out_ch_q;
      out_d       = 1'b0;
      new_cnt     = CW'(1);

      for (int unsigned i = 0; i < NCH; i++) begin
         if (ch_clr[i]) begin
            cnt_d[i]  = '0;
            seen_d[i] = 1'b0;
         end
      end

      // A granted channel is never being flushed, so this cannot collide with the clear above.
      if (grant_vld) begin
         if (seen_q[grant_idx] && (grant_bit == last_q[grant_idx])) begin
            new_cnt = (cnt_q[grant_idx] >= CW'(THRESH)) ? CW'(THRESH)
                                                        : cnt_q[grant_idx] + CW'(1);
         end else begin
            new_cnt = CW'(1);
         end
         cnt_d[grant_idx]  = new_cnt;
         last_d[grant_idx] = grant_bit;
         seen_d[grant_idx] = 1'b1;
         out_valid_d       = 1'b1;
         out_ch_d          = grant_idx;
         out_d             = (new_cnt >= CW'(THRESH));
         rr_ptr_d          = grant_idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         rr_ptr_q    <= '0;
         cnt_q       <= '{default: '0};
         last_q      <= '0;
         seen_q      <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_q       <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         seen_q      <= seen_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_q       <= out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out       = out_q;

endmodule
